// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the multiply/divide unit.
// Holds the R-type funct codes served by the HI/LO unit, the FSM state
// encoding, and a small decoder shared with the ALU control decoder.
package muldiv_pkg;

  // R-type funct codes handled by the HI/LO unit
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Unit FSM: IDLE -> CALC (WIDTH steps) -> FIX (sign fix) -> DONE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Operation class derived from funct
  typedef enum logic [2:0] {
    OPK_MUL     = 3'd0,
    OPK_DIV     = 3'd1,
    OPK_MTHI    = 3'd2,
    OPK_MTLO    = 3'd3,
    OPK_ILLEGAL = 3'd4
  } op_kind_t;

  function automatic op_kind_t decode_funct(input logic [5:0] f);
    op_kind_t k;
    case (f)
      F_MULT, F_MULTU: k = OPK_MUL;
      F_DIV, F_DIVU:   k = OPK_DIV;
      F_MTHI:          k = OPK_MTHI;
      F_MTLO:          k = OPK_MTLO;
      default:         k = OPK_ILLEGAL;
    endcase
    return k;
  endfunction

  // Two's-complement variants
  function automatic logic funct_signed(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step -- one iteration of the sequential multiply/divide datapath.
// Purely combinational; shares a single WIDTH+2 bit adder between the
// shift-add multiply step and the restoring shift-subtract divide step.
//
// Ports:
//   op_div     : 1 = divide step, 0 = multiply step
//   upper      : partial product high half / partial remainder
//   lower      : multiplier (shifting out) / dividend-quotient register
//   operand    : multiplicand magnitude / divisor magnitude
//   next_upper : upper after this iteration
//   next_lower : lower after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_upper,
  output logic [WIDTH-1:0] next_lower
);

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH+1:0] sum_ext;
  logic [WIDTH:0]   mul_t;
  logic             ge;

  always_comb begin
    // Divide: shifted remainder minus divisor via add of inverted operand
    // plus carry-in; carry out (bit WIDTH+1) means "no borrow".
    add_a   = op_div ? {upper, lower[WIDTH-1]} : {1'b0, upper};
    add_b   = op_div ? ~{1'b0, operand} : {1'b0, operand};
    sum_ext = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, op_div};
    ge      = sum_ext[WIDTH+1];

    // Multiply: conditionally add, then shift {carry,upper,lower} right by one
    mul_t   = lower[0] ? sum_ext[WIDTH:0] : {1'b0, upper};

    if (op_div) begin
      next_upper = ge ? sum_ext[WIDTH-1:0] : {upper[WIDTH-2:0], lower[WIDTH-1]};
      next_lower = {lower[WIDTH-2:0], ge};
    end else begin
      next_upper = mul_t[WIDTH:1];
      next_lower = {mul_t[0], lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU,
// MTHI/MTLO). Signed operations run on operand magnitudes; the FIX state
// applies sign correction and the divide-by-zero result before HI/LO load.
//
// Handshake: start is a request strobe sampled on the rising edge; it is
// accepted only while busy is low (FSM in IDLE). A mul/div accepted at edge
// E0 pulses done during the cycle after edge E0+WIDTH+1 (the DONE state);
// MTHI/MTLO pulse done in the cycle right after their accepting edge;
// an unsupported funct pulses illegal in that cycle instead.
//
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset
//   start   : request strobe
//   funct   : R-type funct field
//   a, b    : rs / rt operands
//   busy    : FSM not in IDLE
//   done    : one-cycle completion pulse
//   illegal : one-cycle pulse on unsupported funct
//   hi, lo  : HI / LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic             op_div_q;
  logic             neg_res_q;   // product / quotient needs negation
  logic             neg_rem_q;   // remainder needs negation (dividend < 0)
  logic             div_zero_q;
  logic [WIDTH-1:0] a_q;         // raw dividend, returned in HI on /0
  logic [WIDTH-1:0] upper_q, lower_q, operand_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             mt_done_q, illegal_q;

  // Request decode
  op_kind_t         kind;
  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    kind   = decode_funct(funct);
    accept = start && (state_q == ST_IDLE);
    a_neg  = funct_signed(funct) && a[WIDTH-1];
    b_neg  = funct_signed(funct) && b[WIDTH-1];
    mag_a  = a_neg ? -a : a;
    mag_b  = b_neg ? -b : b;
  end

  // Single iteration datapath
  logic [WIDTH-1:0] step_upper, step_lower;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div     (op_div_q),
    .upper      (upper_q),
    .lower      (lower_q),
    .operand    (operand_q),
    .next_upper (step_upper),
    .next_lower (step_lower)
  );

  // Sign correction, valid while in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

  always_comb begin
    prod     = {upper_q, lower_q};
    prod_fix = neg_res_q ? -prod : prod;
    q_fix    = neg_res_q ? -lower_q : lower_q;
    r_fix    = neg_rem_q ? -upper_q : upper_q;
    if (!op_div_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_hi = r_fix;
      fix_lo = q_fix;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && (kind == OPK_MUL || kind == OPK_DIV)) state_d = ST_CALC;
      ST_CALC: if (count_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE) || mt_done_q;
    illegal = illegal_q;
    hi      = hi_q;
    lo      = lo_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      upper_q    <= '0;
      lower_q    <= '0;
      operand_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mt_done_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      mt_done_q <= 1'b0;
      illegal_q <= 1'b0;
      if (accept) begin
        case (kind)
          OPK_MUL: begin
            op_div_q   <= 1'b0;
            upper_q    <= '0;
            lower_q    <= mag_b;
            operand_q  <= mag_a;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= a;
            count_q    <= CW'(WIDTH - 1);
          end
          OPK_DIV: begin
            op_div_q   <= 1'b1;
            upper_q    <= '0;
            lower_q    <= mag_a;
            operand_q  <= mag_b;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (b == '0);
            a_q        <= a;
            count_q    <= CW'(WIDTH - 1);
          end
          OPK_MTHI: begin
            hi_q      <= a;
            mt_done_q <= 1'b1;
          end
          OPK_MTLO: begin
            lo_q      <= a;
            mt_done_q <= 1'b1;
          end
          default: illegal_q <= 1'b1;
        endcase
      end else if (state_q == ST_CALC) begin
        upper_q <= step_upper;
        lower_q <= step_lower;
        if (count_q != '0) count_q <= count_q - CW'(1);
      end else if (state_q == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit (WIDTH = 32).
// Inputs are driven and outputs sampled on the falling edge; cycle n after
// an accepting edge is the n-th falling edge following it.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = 6'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, illegal;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .illegal(illegal), .hi(hi), .lo(lo)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Mul/div transaction: accept, scramble inputs, wait for done, check
  // latency, result and the return to idle.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [2*W-1:0] expv);
    int n;
    logic [2*W-1:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b1; funct = f; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; funct = 6'($urandom_range(0, 63));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    if (done === 1'b1) begin
      e = exp_q.pop_front();
      check({tag, "_res"}, {hi, lo}, e);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // MTHI/MTLO transaction
  task automatic run_mt(input string tag, input logic [5:0] f, input logic [W-1:0] xa,
                        input logic [2*W-1:0] expv);
    @(negedge clk);
    start = 1'b1; funct = f; a = xa;
    @(negedge clk);
    start = 1'b0; a = $urandom;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_res"}, {hi, lo}, expv);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dones;
    int lat;
    logic [2*W-1:0] e;

    // Reset state
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    // Multiply / divide vectors
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd5,        {32'hFFFFFFFF, 32'hFFFFFFF1});
    run_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu_zero", F_DIVU,  32'd10,       32'd0,        {32'h0000000A, 32'hFFFFFFFF});
    run_op("divu_100_7", F_DIVU, 32'd100,      32'd7,        {32'd2, 32'd14});
    run_op("div_7_m2",  F_DIV,   32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
    run_op("mult_min",  F_MULT,  32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000});
    run_op("mult_m1",   F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001});
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});

    // HI/LO moves and illegal funct
    run_mt("mthi", F_MTHI, 32'h12345678, {32'h12345678, 32'h80000000});
    run_mt("mtlo", F_MTLO, 32'hCAFEF00D, {32'h12345678, 32'hCAFEF00D});
    @(negedge clk);
    start = 1'b1; funct = 6'b100000; a = 32'h55555555; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("ill_pulse", 64'(illegal), 64'd1);
    check("ill_busy", 64'(busy), 64'd0);
    check("ill_done", 64'(done), 64'd0);
    check("ill_hilo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});
    @(negedge clk);
    check("ill_once", 64'(illegal), 64'd0);

    // Start while busy is ignored
    exp_q.push_back({32'd0, 32'd12});
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    dones = 0; lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin
        start = 1'b1; funct = F_DIVU; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          e = exp_q.pop_front();
          check("ovl_res", {hi, lo}, e);
        end
      end
      @(negedge clk);
    end
    check("ovl_dones", 64'(dones), 64'd1);
    check("ovl_lat", 64'(lat), 64'(LAT));
    check("ovl_idle", 64'(busy), 64'd0);

    run_op("div_szero", F_DIV, 32'hFFFFFFF8, 32'd0, {32'hFFFFFFF8, 32'hFFFFFFFF});

    // Reset in the middle of a divide; start during reset is ignored
    @(negedge clk);
    start = 1'b1; funct = F_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0; start = 1'b1; funct = F_MULTU; a = 32'd6; b = 32'd7;
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_hilo", {hi, lo}, 64'd0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    check("mrst_quiet", 64'(dones), 64'd0);
    run_op("multu_6_7", F_MULTU, 32'd6, 32'd7, {32'd0, 32'd42});

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; even, >= 4.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  in  1  request strobe, sampled on rising edge.
REQ-005 SHALL have port: funct  in  6  R-type funct field selecting operation.
REQ-006 SHALL have port: a  in  WIDTH  rs operand (dividend / multiplicand).
REQ-007 SHALL have port: b  in  WIDTH  rt operand (divisor / multiplier).
REQ-008 SHALL have port: busy  out  1  high whenever FSM is not IDLE.
REQ-009 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: illegal  out  1  one-cycle pulse on unsupported funct.
REQ-011 SHALL have port: hi  out  WIDTH  HI register (registered output, MFHI source).
REQ-012 SHALL have port: lo  out  WIDTH  LO register (registered output, MFLO source).

Function
REQ-013 SHALL decode funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; every other code is unsupported.
REQ-014 SHALL accept start only in IDLE; start while busy is ignored and operands are not re-sampled.
REQ-015 SHALL latch a, b and funct on the accepting edge; later changes to inputs have no effect.
REQ-016 SHALL implement FSM states IDLE -> CALC -> FIX -> DONE -> IDLE for mul/div.
REQ-017 SHALL stay in CALC exactly WIDTH cycles, one shift-add (mul) or restoring shift-subtract (div) step per cycle, counter counting WIDTH-1 down to 0.
REQ-018 SHALL use FIX for one cycle to apply sign correction; hi/lo SHALL update on the edge entering DONE.
REQ-019 SHALL assert done for exactly one cycle in DONE, WIDTH+2 cycles after the accepting edge; busy SHALL fall on that same edge, giving a new start acceptance edge no earlier than the edge leaving DONE.
REQ-020 SHALL, for MTHI/MTLO in IDLE, write a into hi/lo on the accepting edge, leave the other register unchanged, pulse done the next cycle, and never raise busy.
REQ-021 SHALL, for unsupported funct with start in IDLE, pulse illegal for one cycle after the edge and leave state, hi and lo unchanged.
REQ-022 SHALL compute multiply as the 2*WIDTH-bit product: {hi,lo}; MULT is signed two's-complement, MULTU unsigned.
REQ-023 SHALL compute divide as lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-024 SHALL produce for divisor 0: lo = all ones, hi = a (signed and unsigned).
REQ-025 SHALL produce for DIV most-negative / -1: lo = most-negative, hi = 0, without fault.
REQ-026 SHALL keep hi/lo stable at all times except the update edges of REQ-018/REQ-020.

Reset
REQ-027 SHALL, when rst = 0 at a rising edge, force IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0, illegal = 0.
REQ-028 SHALL, on reset mid-operation, discard all partial results with no done pulse; start in the same cycle as rst = 0 is ignored.

Structure
REQ-029 SHALL place funct code constants and the FSM state enum in shared package muldiv_pkg, also consumed by the ALU control decoder.
REQ-030 SHALL instantiate one sub-module muldiv_step: combinational single-iteration datapath (add/subtract, shift, select) parametrised by WIDTH.

Verification (WIDTH = 32)
REQ-031 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL cover: MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL cover: DIVU a=10 b=0 -> lo=0xFFFFFFFF, hi=0x0000000A; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: start MULTU then second start (DIVU) at cycle 5 with changed operands -> ignored, single done, first result only.
REQ-035 SHALL cover: MTHI a=0x12345678 -> hi=0x12345678 next edge, lo unchanged, busy stays 0; funct 100000 -> illegal pulse, hi/lo unchanged.
REQ-036 SHALL cover: rst low at cycle 10 of DIV -> busy 0, hi=lo=0, no done; subsequent MULTU 6*7 -> lo=42 at 34 cycles.
